// File: rtl/maze_player_ctrl.sv
// maze_player_ctrl: turns button presses into wall-checked single-tile player moves via the level lookup.
// Define MAZE_AUTOREPEAT_EN to re-issue a held direction every REPEAT_TICKS cycles.
module maze_player_ctrl #(
  parameter logic [2:0]  START_ROW    = 3'd0,
  parameter logic [2:0]  START_COL    = 3'd0,
  parameter logic [2:0]  GOAL_ROW     = 3'd4,
  parameter logic [2:0]  GOAL_COL     = 3'd4,
  parameter int unsigned REPEAT_TICKS = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  input  logic       i_btn_left,
  input  logic       i_btn_right,
  input  logic       i_level_restart,
  input  logic [2:0] i_num_rows,
  input  logic [2:0] i_num_cols,
  output logic [2:0] o_maze_row,
  output logic [2:0] o_maze_col,
  input  logic [3:0] i_maze_walls,
  output logic [2:0] o_player_row,
  output logic [2:0] o_player_col,
  output logic       o_move_done,
  output logic       o_bump,
  output logic       o_at_goal
);
  typedef enum logic [1:0] {IDLE, RD_CUR, RD_NXT, COMMIT} state_t;
  state_t r_state, w_state_nxt;
  logic [3:0] r_sync1, r_sync2, r_prev, r_dir, w_edge, w_req, w_rpt, w_opp;
  logic [2:0] r_arm, r_row, r_col, r_tgt_row, r_tgt_col, r_maze_row, r_maze_col, w_tgt_row, w_tgt_col;
  logic r_done, r_bump, r_goal, w_done_nxt, w_bump_nxt, w_cur_blk, w_nxt_blk, w_addr_tgt;

  function automatic logic [3:0] prio(input logic [3:0] v);
    return v[3] ? 4'b1000 : v[2] ? 4'b0100 : v[1] ? 4'b0010 : v[0] ? 4'b0001 : 4'b0000;
  endfunction

  // Edges stay disarmed until the synchroniser holds post-reset samples, so a held button never fires.
  assign w_edge = r_sync2 & ~r_prev & {4{r_arm[2]}};
  assign w_req  = r_goal ? 4'd0 : prio(w_edge | w_rpt);

`ifdef MAZE_AUTOREPEAT_EN
  logic [31:0] r_rpt_cnt;
  logic [3:0]  r_rpt_dir, w_held;
  assign w_held = prio(r_sync2);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rpt_cnt <= '0;
      r_rpt_dir <= '0;
    end else if (i_level_restart || w_held != r_rpt_dir || r_rpt_cnt == REPEAT_TICKS - 1) begin
      r_rpt_cnt <= '0;
      r_rpt_dir <= w_held;
    end else
      r_rpt_cnt <= r_rpt_cnt + 32'd1;
  assign w_rpt = (w_held == r_rpt_dir && r_rpt_cnt == REPEAT_TICKS - 1 && r_arm[2]) ? w_held : 4'd0;
`else
  assign w_rpt = 4'd0;
`endif

  // Wall code and direction share the {T,B,L,R} / {up,down,left,right} ordering.
  assign w_opp      = {r_dir[2], r_dir[3], r_dir[0], r_dir[1]};
  assign w_cur_blk  = |(r_dir & i_maze_walls) || (r_dir[3] && r_row == 3'd0) ||
                      (r_dir[2] && r_row == i_num_rows - 3'd1) || (r_dir[1] && r_col == 3'd0) ||
                      (r_dir[0] && r_col == i_num_cols - 3'd1);
  assign w_nxt_blk  = |(w_opp & i_maze_walls);
  assign w_tgt_row  = w_req[3] ? r_row - 3'd1 : w_req[2] ? r_row + 3'd1 : r_row;
  assign w_tgt_col  = w_req[1] ? r_col - 3'd1 : w_req[0] ? r_col + 3'd1 : r_col;
  assign w_addr_tgt = w_state_nxt == RD_NXT || w_state_nxt == COMMIT || r_state == COMMIT;

  always_comb begin
    w_state_nxt = r_state;
    w_bump_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    if (i_level_restart)
      w_state_nxt = IDLE;
    else
      case (r_state)
        IDLE:    w_state_nxt = |w_req ? RD_CUR : IDLE;
        RD_CUR: begin
          w_state_nxt = w_cur_blk ? IDLE : RD_NXT;
          w_bump_nxt  = w_cur_blk;
        end
        RD_NXT: begin
          w_state_nxt = w_nxt_blk ? IDLE : COMMIT;
          w_bump_nxt  = w_nxt_blk;
          w_done_nxt  = !w_nxt_blk;
        end
        default: w_state_nxt = IDLE;
      endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_prev     <= '0;
      r_arm      <= '0;
      r_state    <= IDLE;
      r_dir      <= '0;
      r_tgt_row  <= START_ROW;
      r_tgt_col  <= START_COL;
      r_row      <= START_ROW;
      r_col      <= START_COL;
      r_maze_row <= START_ROW;
      r_maze_col <= START_COL;
      r_done     <= 1'b0;
      r_bump     <= 1'b0;
      r_goal     <= START_ROW == GOAL_ROW && START_COL == GOAL_COL;
    end else begin
      r_sync1 <= {i_btn_up, i_btn_down, i_btn_left, i_btn_right};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_arm   <= {r_arm[1:0], 1'b1};
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      r_bump  <= w_bump_nxt;
      if (i_level_restart) begin
        r_row      <= START_ROW;
        r_col      <= START_COL;
        r_maze_row <= START_ROW;
        r_maze_col <= START_COL;
        r_goal     <= START_ROW == GOAL_ROW && START_COL == GOAL_COL;
      end else begin
        if (r_state == IDLE && |w_req) begin
          r_dir     <= w_req;
          r_tgt_row <= w_tgt_row;
          r_tgt_col <= w_tgt_col;
        end
        if (r_state == COMMIT) begin
          r_row  <= r_tgt_row;
          r_col  <= r_tgt_col;
          r_goal <= r_tgt_row == GOAL_ROW && r_tgt_col == GOAL_COL;
        end
        r_maze_row <= w_addr_tgt ? r_tgt_row : r_row;
        r_maze_col <= w_addr_tgt ? r_tgt_col : r_col;
      end
    end

  assign o_maze_row   = r_maze_row;
  assign o_maze_col   = r_maze_col;
  assign o_player_row = r_row;
  assign o_player_col = r_col;
  assign o_at_goal    = r_goal;
  assign o_move_done  = r_done & ~i_level_restart;
  assign o_bump       = r_bump & ~i_level_restart;
endmodule

// File: tb/tb_maze_player_ctrl.sv
// tb_maze_player_ctrl: directed walk through a 5x5 stub maze with a scoreboard of per-cycle expectations.
module tb_maze_player_ctrl;
  localparam int O_COM = 0, O_CUR = 1, O_NXT = 2, O_IGN = 3, O_RST = 4;
  localparam logic [14:0] ZERO = 15'd0;
  logic clk = 1'b0, rst_n = 1'b0;
  logic i_btn_up = 1'b0, i_btn_down = 1'b0, i_btn_left = 1'b0, i_btn_right = 1'b0, i_level_restart = 1'b0;
  logic [2:0] i_num_rows = 3'd5, i_num_cols = 3'd5;
  logic [2:0] o_maze_row, o_maze_col, o_player_row, o_player_col;
  logic [3:0] i_maze_walls;
  logic o_move_done, o_bump, o_at_goal;
  int n_asrt = 0, n_fail = 0;
  logic [14:0] q[$];
  logic [2:0] pr = 3'd0, pc = 3'd0;
  logic pg = 1'b0;

  always #5 clk = ~clk;

  maze_player_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .i_btn_up(i_btn_up), .i_btn_down(i_btn_down), .i_btn_left(i_btn_left), .i_btn_right(i_btn_right),
    .i_level_restart(i_level_restart), .i_num_rows(i_num_rows), .i_num_cols(i_num_cols),
    .o_maze_row(o_maze_row), .o_maze_col(o_maze_col), .i_maze_walls(i_maze_walls),
    .o_player_row(o_player_row), .o_player_col(o_player_col),
    .o_move_done(o_move_done), .o_bump(o_bump), .o_at_goal(o_at_goal)
  );

  // Stub level lookup: {T,B,L,R}, every cell not listed is fully open (including (0,4)).
  function automatic logic [3:0] walls(input logic [2:0] r, input logic [2:0] c);
    case ({r, c})
      6'o00:   return 4'b1110;
      6'o20:   return 4'b0111;
      6'o12:   return 4'b0110;
      default: return 4'b0000;
    endcase
  endfunction

  always_comb i_maze_walls = walls(o_maze_row, o_maze_col);

  function automatic logic [14:0] pk(input logic [2:0] mr, input logic [2:0] mc, input logic [2:0] rr,
                                     input logic [2:0] cc, input logic d, input logic b, input logic g);
    return {mr, mc, rr, cc, d, b, g};
  endfunction

  function automatic logic [14:0] obs();
    return pk(o_maze_row, o_maze_col, o_player_row, o_player_col, o_move_done, o_bump, o_at_goal);
  endfunction

  task automatic chk(input string tag, input logic [14:0] got, input logic [14:0] exp);
    n_asrt++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed={mr,mc,pr,pc,done,bump,goal}=%b expected=%b", tag, got, exp);
    end
  endtask

  // Mask order {up,down,left,right}; expectations cover cycles 0..4 after the synchronised edge.
  task automatic press(input string name, input logic [3:0] m, input int oc);
    logic [2:0] tr, tc;
    logic [14:0] base;
    logic tg;
    tr = m[3] ? pr - 3'd1 : m[2] ? pr + 3'd1 : pr;
    tc = (m[3] | m[2]) ? pc : m[1] ? pc - 3'd1 : pc + 3'd1;
    tg = (tr == 3'd4) && (tc == 3'd4);
    base = pk(pr, pc, pr, pc, 1'b0, 1'b0, pg);
    q.push_back(base);
    q.push_back(base);
    case (oc)
      O_CUR: begin
        q.push_back(pk(pr, pc, pr, pc, 1'b0, 1'b1, pg));
        q.push_back(base);
        q.push_back(base);
      end
      O_NXT: begin
        q.push_back(pk(tr, tc, pr, pc, 1'b0, 1'b0, pg));
        q.push_back(pk(pr, pc, pr, pc, 1'b0, 1'b1, pg));
        q.push_back(base);
      end
      O_COM: begin
        q.push_back(pk(tr, tc, pr, pc, 1'b0, 1'b0, pg));
        q.push_back(pk(tr, tc, pr, pc, 1'b1, 1'b0, pg));
        q.push_back(pk(tr, tc, tr, tc, 1'b0, 1'b0, tg));
      end
      O_RST: begin
        q.push_back(pk(tr, tc, pr, pc, 1'b0, 1'b0, pg));
        q.push_back(ZERO);
        q.push_back(ZERO);
      end
      default: begin
        q.push_back(base);
        q.push_back(base);
        q.push_back(base);
      end
    endcase
    {i_btn_up, i_btn_down, i_btn_left, i_btn_right} = m;
    for (int i = -1; i < 5; i++) begin
      @(posedge clk);
      #1;
      i_level_restart = (oc == O_RST) && (i == 2);
      @(negedge clk);
      if (i >= 0) chk($sformatf("%s c%0d", name, i), obs(), q.pop_front());
    end
    if (oc == O_COM) begin
      pr = tr;
      pc = tc;
      pg = tg;
    end else if (oc == O_RST) begin
      pr = 3'd0;
      pc = 3'd0;
      pg = 1'b0;
    end
    {i_btn_up, i_btn_down, i_btn_left, i_btn_right} = 4'b0000;
    i_level_restart = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    i_btn_right = 1'b1;
    q.push_back(ZERO);
    @(negedge clk);
    chk("in_reset", obs(), q.pop_front());
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      q.push_back(ZERO);
      @(negedge clk);
      chk($sformatf("held_through_reset c%0d", i), obs(), q.pop_front());
    end
    i_btn_right = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    press("down_wall_00", 4'b0100, O_CUR);
    press("right_to_01", 4'b0001, O_COM);
    press("down_to_11", 4'b0100, O_COM);
    press("down_to_21", 4'b0100, O_COM);
    press("left_nxt_wall_21", 4'b0010, O_NXT);
    press("right_to_22", 4'b0001, O_COM);
    press("up_nxt_wall_22", 4'b1000, O_NXT);
    press("right_to_23", 4'b0001, O_COM);
    press("up_to_13", 4'b1000, O_COM);
    press("left_to_12", 4'b0010, O_COM);
    press("up_right_prio", 4'b1001, O_COM);
    press("right_to_03", 4'b0001, O_COM);
    press("right_to_04", 4'b0001, O_COM);
    press("up_offgrid_04", 4'b1000, O_CUR);
    press("right_offgrid_04", 4'b0001, O_CUR);
    press("down_to_14", 4'b0100, O_COM);
    press("down_to_24", 4'b0100, O_COM);
    press("down_to_34", 4'b0100, O_COM);
    press("down_to_goal", 4'b0100, O_COM);
    press("left_at_goal", 4'b0010, O_IGN);
    i_level_restart = 1'b1;
    @(posedge clk);
    #1 i_level_restart = 1'b0;
    q.push_back(ZERO);
    @(negedge clk);
    chk("restart_from_goal", obs(), q.pop_front());
    pr = 3'd0;
    pc = 3'd0;
    pg = 1'b0;
    @(posedge clk);
    #1;
    press("right_after_restart", 4'b0001, O_COM);
    press("restart_mid_rd_nxt", 4'b0001, O_RST);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
